// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the 8x8 DCT coefficient sequencer.
package dct_pkg;
  localparam int unsigned N      = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned ADDR_W = 2 * IDX_W;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SPIX_W = PIX_W + 1;
  localparam int unsigned COS_W  = 32;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned COEF_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/dct_coeff_sequencer_if.sv
// Pixel-RAM read port and cosine-LUT lookup bus between the sequencer and its memories.
interface dct_coeff_sequencer_if;
  import dct_pkg::*;

  logic                     pix_rd;
  logic [ADDR_W-1:0]        pix_addr;
  logic [PIX_W-1:0]         pix_data;
  logic [IDX_W-1:0]         lut_k1;
  logic [IDX_W-1:0]         lut_k2;
  logic [IDX_W-1:0]         lut_n1;
  logic [IDX_W-1:0]         lut_n2;
  logic signed [COS_W-1:0]  cos_term;

  modport master (
    output pix_rd, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
    input  pix_data, cos_term
  );

  modport slave (
    input  pix_rd, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
    output pix_data, cos_term
  );
endinterface

// File: rtl/dct_mac.sv
// Level-shifted pixel times cosine weight, accumulated into a 48-bit signed sum.
module dct_mac import dct_pkg::*; #(
  parameter int LEVEL_SHIFT = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic [PIX_W-1:0]         pixel,
  input  logic signed [COS_W-1:0]  cos,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [SPIX_W-1:0]       pix_s;
  logic signed [SPIX_W+COS_W-1:0] prod;

  always_comb begin
    pix_s = $signed({1'b0, pixel}) - $signed(SPIX_W'(LEVEL_SHIFT));
    prod  = pix_s * cos;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/dct_coeff_sequencer.sv
// Sequences 64 pixel reads and LUT lookups for one 2-D DCT coefficient (k1,k2).
module dct_coeff_sequencer import dct_pkg::*; #(
  parameter int unsigned FRAC_BITS   = 8,
  parameter int          LEVEL_SHIFT = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W-1:0]          k1,
  input  logic [IDX_W-1:0]          k2,
  output logic                      busy,
  output logic signed [COEF_W-1:0]  coeff,
  output logic                      coeff_valid,
  dct_coeff_sequencer_if.master     mem
);
  state_t                   state;
  state_t                   state_next;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        idx_d;
  logic [IDX_W-1:0]         k1_q;
  logic [IDX_W-1:0]         k2_q;
  logic                     acc_en;
  logic                     accept;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coeff_q;
  logic signed [COEF_W-1:0] coeff_new;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == '1) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == IDLE) && start;
    busy        = (state != IDLE);
    coeff_valid = (state == OUT);
    coeff_new   = COEF_W'(acc >>> FRAC_BITS);
    coeff       = coeff_valid ? coeff_new : coeff_q;
  end

  // The index feeds pix_addr directly; its one-cycle-delayed copy drives the LUT
  // so cos_term lines up with the registered pixel read.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      idx_d   <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      acc_en  <= 1'b0;
      coeff_q <= '0;
    end else begin
      idx_d  <= idx;
      acc_en <= (state == RUN);
      if (accept) begin
        k1_q <= k1;
        k2_q <= k2;
        idx  <= '0;
      end else if (state == RUN) begin
        idx <= idx + ADDR_W'(1);
      end
      if (state == OUT) coeff_q <= coeff_new;
    end
  end

  assign mem.pix_rd   = (state == RUN);
  assign mem.pix_addr = idx;
  assign mem.lut_k1   = k1_q;
  assign mem.lut_k2   = k2_q;
  assign mem.lut_n1   = idx_d[ADDR_W-1:IDX_W];
  assign mem.lut_n2   = idx_d[IDX_W-1:0];

  dct_mac #(.LEVEL_SHIFT(LEVEL_SHIFT)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (acc_en),
    .pixel (mem.pix_data),
    .cos   (mem.cos_term),
    .acc   (acc)
  );
endmodule

// File: tb/tb_dct_coeff_sequencer.sv
// Directed bench: table of pixel/LUT patterns with hand-computed coefficients plus reset and back-to-back sequences.
module tb_dct_coeff_sequencer;
  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [2:0]         k1;
  logic [2:0]         k2;
  logic               busy;
  logic signed [31:0] coeff;
  logic               coeff_valid;

  dct_coeff_sequencer_if mem ();

  dct_coeff_sequencer #(.FRAC_BITS(8), .LEVEL_SHIFT(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k1          (k1),
    .k2          (k2),
    .busy        (busy),
    .coeff       (coeff),
    .coeff_valid (coeff_valid),
    .mem         (mem)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [64];
  bit         cos_diag;
  int         cos_val;

  always @(posedge clk) if (mem.pix_rd) mem.pix_data <= ram[mem.pix_addr];
  assign mem.cos_term = cos_diag ? ((mem.lut_n1 == mem.lut_n2) ? 32'sd256 : 32'sd0) : 32'(cos_val);

  typedef struct {
    bit         ramp;
    bit         diag;
    logic [7:0] fill;
    int         cval;
    logic [2:0] ka;
    logic [2:0] kb;
    int         poke;
    int         exp;
  } vec_t;

  vec_t vt[10];
  int   nvec = 0;
  int   nbad = 0;

  task automatic check(input string name, input logic signed [47:0] act, input logic signed [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit ramp, input bit diag, input logic [7:0] fill, input int cval);
    for (int i = 0; i < 64; i++) ram[i] = ramp ? 8'(i) : fill;
    cos_diag = diag;
    cos_val  = cval;
  endtask

  // Caller is in an idle cycle; that cycle becomes cycle 0 of the computation.
  task automatic run_coeff(input string tag, input int exp, input logic [2:0] ka, input logic [2:0] kb, input int poke);
    k1 = ka; k2 = kb; start = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      tick();
      start = (c == poke);
      if (c == poke) begin k1 = ~ka; k2 = ~kb; end
      check({tag, ":busy"}, busy, c <= 66);
      check({tag, ":pix_rd"}, mem.pix_rd, c <= 64);
      check({tag, ":valid"}, coeff_valid, c == 66);
      if (c <= 64) check({tag, ":pix_addr"}, mem.pix_addr, c - 1);
      if (c >= 2 && c <= 65) check({tag, ":lut_n"}, {mem.lut_n1, mem.lut_n2}, c - 2);
      if (c <= 66) check({tag, ":lut_k"}, {mem.lut_k1, mem.lut_k2}, {ka, kb});
      if (c >= 66) check({tag, ":coeff"}, coeff, exp);
    end
    start = 1'b0;
  endtask

  initial begin
    vt[0] = '{ramp:0, diag:0, fill:8'd129, cval:256,   ka:3'd1, kb:3'd4, poke:20, exp:64};
    vt[1] = '{ramp:0, diag:0, fill:8'd127, cval:256,   ka:3'd2, kb:3'd3, poke:-1, exp:-64};
    vt[2] = '{ramp:0, diag:1, fill:8'd128, cval:0,     ka:3'd5, kb:3'd0, poke:-1, exp:0};
    vt[3] = '{ramp:0, diag:0, fill:8'd128, cval:-7777, ka:3'd6, kb:3'd6, poke:-1, exp:0};
    vt[4] = '{ramp:1, diag:1, fill:8'd0,   cval:0,     ka:3'd7, kb:3'd7, poke:-1, exp:-772};
    vt[5] = '{ramp:0, diag:0, fill:8'd0,   cval:256,   ka:3'd0, kb:3'd1, poke:-1, exp:-8192};
    vt[6] = '{ramp:0, diag:0, fill:8'd255, cval:-256,  ka:3'd4, kb:3'd2, poke:-1, exp:-8128};
    vt[7] = '{ramp:0, diag:0, fill:8'd130, cval:3,     ka:3'd3, kb:3'd3, poke:-1, exp:1};
    vt[8] = '{ramp:0, diag:0, fill:8'd126, cval:3,     ka:3'd1, kb:3'd6, poke:-1, exp:-2};
    vt[9] = '{ramp:1, diag:0, fill:8'd0,   cval:256,   ka:3'd2, kb:3'd5, poke:-1, exp:-6176};

    rst = 1'b1; start = 1'b0; k1 = '0; k2 = '0;
    load(0, 0, 8'd128, 0);
    tick(); tick();
    check("rst:busy", busy, 0);
    check("rst:pix_rd", mem.pix_rd, 0);
    check("rst:pix_addr", mem.pix_addr, 0);
    check("rst:lut_n", {mem.lut_n1, mem.lut_n2}, 0);
    check("rst:lut_k", {mem.lut_k1, mem.lut_k2}, 0);
    check("rst:coeff", coeff, 0);
    check("rst:valid", coeff_valid, 0);
    check("rst:acc", dut.acc, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      load(vt[v].ramp, vt[v].diag, vt[v].fill, vt[v].cval);
      run_coeff($sformatf("vec%0d", v), vt[v].exp, vt[v].ka, vt[v].kb, vt[v].poke);
    end

    // Reset mid-RUN aborts the computation without a result pulse.
    load(0, 0, 8'd129, 256);
    k1 = 3'd3; k2 = 3'd5; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      if (c == 30) rst = 1'b1;
    end
    tick();
    rst = 1'b0;
    check("abort:busy", busy, 0);
    check("abort:valid", coeff_valid, 0);
    check("abort:pix_rd", mem.pix_rd, 0);
    check("abort:coeff", coeff, 0);
    check("abort:lut_k", {mem.lut_k1, mem.lut_k2}, 0);
    check("abort:acc", dut.acc, 0);
    for (int c = 0; c < 45; c++) begin
      tick();
      check("abort:idle_valid", coeff_valid, 0);
      check("abort:idle_busy", busy, 0);
    end
    run_coeff("post_rst", 64, 3'd2, 3'd6, -1);

    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_prio:busy", busy, 0);
    tick();
    check("rst_prio:busy2", busy, 0);

    // Start held high: back-to-back coefficients every 67 cycles.
    load(1, 1, 8'd0, 0);
    k1 = 3'd1; k2 = 3'd2; start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      int ph;
      tick();
      ph = c % 67;
      check("held:busy", busy, ph != 0);
      check("held:pix_rd", mem.pix_rd, ph >= 1 && ph <= 64);
      check("held:valid", coeff_valid, ph == 66);
      if (ph >= 1 && ph <= 64) check("held:pix_addr", mem.pix_addr, ph - 1);
      if (ph == 66) check("held:coeff", coeff, -772);
    end
    start = 1'b0;
    tick(); tick();
    check("held:stop_busy", busy, 0);
    check("held:hold_coeff", coeff, -772);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
